// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: register write request bus between the command parser and the configuration space
// Signals: reg_req (held until acked), reg_addr[7:0], reg_wdata[15:0], reg_ack.
// master drives the request side; slave accepts it and returns reg_ack.
interface uart_cmd_ctrl_if;
  logic        reg_req;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_ack;
  modport master (output reg_req, reg_addr, reg_wdata, input reg_ack);
  modport slave (input reg_req, reg_addr, reg_wdata, output reg_ack);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses HDR0 HDR1 ADDR DH DL CHK byte frames from a UART receiver into register writes
// Ports: I_clk, I_rstn (synchronous, active-low); I_uart_rdata/I_uart_rvalid received byte stream,
//        one byte per rising edge of rvalid; bus (master) register write request/ack handshake;
//        I_err_clr clears O_err_cnt; O_busy is high outside IDLE; O_err_cnt saturating error count.
// Optional: define UART_CMD_TIMEOUT_EN to abandon a partial frame after TIMEOUT_CYC idle cycles.
module uart_cmd_ctrl #(
  parameter logic [7:0] HDR0 = 8'h55,
  parameter logic [7:0] HDR1 = 8'hAA
`ifdef UART_CMD_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1_000_000
`endif
) (
  input  logic            I_clk,
  input  logic            I_rstn,
  input  logic [7:0]      I_uart_rdata,
  input  logic            I_uart_rvalid,
  input  logic            I_err_clr,
  uart_cmd_ctrl_if.master bus,
  output logic            O_busy,
  output logic [7:0]      O_err_cnt
);
  localparam logic [2:0] IDLE = 3'd0, H1 = 3'd1, ADDR = 3'd2, DH = 3'd3, DL = 3'd4, CHK = 3'd5, WAIT = 3'd6;
  logic [2:0] state, state_n;
  logic       rv_q, ev, err_ev, chk_ok;
  logic [7:0] addr_h, dh_h, dl_h;
  assign ev = I_uart_rvalid & ~rv_q;
  assign chk_ok = I_uart_rdata == (addr_h ^ dh_h ^ dl_h);
  assign O_busy = state != IDLE;
`ifdef UART_CMD_TIMEOUT_EN
  logic [19:0] tmo_cnt;
  logic        tmo_run, tmo_hit;
  assign tmo_run = state inside {H1, ADDR, DH, DL, CHK};
  // an arriving byte beats expiry in the same cycle
  assign tmo_hit = tmo_run && !ev && tmo_cnt == 20'(TIMEOUT_CYC - 1);
`endif
  always_comb begin
    state_n = state > WAIT ? IDLE : state;
    err_ev = 1'b0;
    if (ev)
      case (state)
        IDLE: state_n = I_uart_rdata == HDR0 ? H1 : IDLE;
        H1: state_n = I_uart_rdata == HDR1 ? ADDR : I_uart_rdata == HDR0 ? H1 : IDLE;
        ADDR: state_n = DH;
        DH: state_n = DL;
        DL: state_n = CHK;
        CHK: begin
          state_n = chk_ok ? WAIT : IDLE;
          err_ev = !chk_ok;
        end
        WAIT: err_ev = 1'b1;
        default: state_n = IDLE;
      endcase
    if (state == WAIT && bus.reg_ack) state_n = IDLE;
`ifdef UART_CMD_TIMEOUT_EN
    if (tmo_hit) begin
      state_n = IDLE;
      err_ev = 1'b1;
    end
`endif
  end
  always_ff @(posedge I_clk) begin
    if (!I_rstn) begin
      state <= IDLE;
      rv_q <= 1'b0;
      addr_h <= '0;
      dh_h <= '0;
      dl_h <= '0;
      bus.reg_req <= 1'b0;
      bus.reg_addr <= '0;
      bus.reg_wdata <= '0;
      O_err_cnt <= '0;
    end else begin
      state <= state_n;
      rv_q <= I_uart_rvalid;
      if (ev && state == ADDR) addr_h <= I_uart_rdata;
      if (ev && state == DH) dh_h <= I_uart_rdata;
      if (ev && state == DL) dl_h <= I_uart_rdata;
      if (ev && state == CHK && chk_ok) begin
        bus.reg_addr <= addr_h;
        bus.reg_wdata <= {dh_h, dl_h};
        bus.reg_req <= 1'b1;
      end else if (state == WAIT && bus.reg_ack) bus.reg_req <= 1'b0;
      O_err_cnt <= I_err_clr ? 8'd0 : O_err_cnt + 8'(err_ev && O_err_cnt != 8'hFF);
    end
  end
`ifdef UART_CMD_TIMEOUT_EN
  always_ff @(posedge I_clk) begin
    if (!I_rstn) tmo_cnt <= '0;
    else if (ev || state_n == IDLE || state_n == WAIT) tmo_cnt <= '0;
    else if (tmo_run) tmo_cnt <= tmo_cnt + 20'd1;
  end
`endif
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and randomized frame traffic checked against a frame-level reference model
module tb_uart_cmd_ctrl;
  localparam int TO = 40;
  logic       I_clk = 1'b0;
  logic       I_rstn = 1'b0;
  logic       I_uart_rvalid = 1'b0;
  logic       I_err_clr = 1'b0;
  logic [7:0] I_uart_rdata = 8'h00;
  logic       O_busy;
  logic [7:0] O_err_cnt;
  int checks = 0;
  int errors = 0;
  uart_cmd_ctrl_if bus();
  always #5 I_clk = ~I_clk;
`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
`else
  uart_cmd_ctrl dut (
`endif
    .I_clk(I_clk), .I_rstn(I_rstn), .I_uart_rdata(I_uart_rdata), .I_uart_rvalid(I_uart_rvalid),
    .I_err_clr(I_err_clr), .bus(bus.master), .O_busy(O_busy), .O_err_cnt(O_err_cnt));
  bit         m_rv, m_pend;
  logic [7:0] q[$];
  logic [7:0] m_addr, m_err;
  logic [15:0] m_wdata;
  int         m_idle;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step();
    bit ev, was, inc;
    ev = I_uart_rvalid && !m_rv;
    was = m_pend;
    inc = 0;
    m_rv = I_uart_rvalid;
    if (!I_rstn) begin
      m_rv = 0; m_pend = 0; q.delete(); m_addr = 0; m_wdata = 0; m_err = 0; m_idle = 0;
      return;
    end
    if (ev) begin
      m_idle = 0;
      if (was) inc = 1;
      else if (q.size() == 0) begin
        if (I_uart_rdata == 8'h55) q.push_back(I_uart_rdata);
      end else if (q.size() == 1) begin
        if (I_uart_rdata == 8'hAA) q.push_back(I_uart_rdata);
        else if (I_uart_rdata != 8'h55) q.delete();
      end else if (q.size() < 5) q.push_back(I_uart_rdata);
      else begin
        if (I_uart_rdata == (q[2] ^ q[3] ^ q[4])) begin
          m_pend = 1; m_addr = q[2]; m_wdata = {q[3], q[4]};
        end else inc = 1;
        q.delete();
      end
    end
`ifdef UART_CMD_TIMEOUT_EN
    else if (q.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        q.delete(); m_idle = 0; inc = 1;
      end
    end
`endif
    if (was && bus.reg_ack) m_pend = 0;
    m_err = I_err_clr ? 8'd0 : (inc && m_err != 8'hFF) ? m_err + 8'd1 : m_err;
  endtask
  task automatic tick();
    @(posedge I_clk);
    model_step();
    #1;
    check("req", 32'(bus.reg_req), 32'(m_pend));
    check("busy", 32'(O_busy), 32'(q.size() > 0 || m_pend));
    check("addr", 32'(bus.reg_addr), 32'(m_addr));
    check("wdata", 32'(bus.reg_wdata), 32'(m_wdata));
    check("err_cnt", 32'(O_err_cnt), 32'(m_err));
  endtask
  task automatic send(input logic [7:0] b, input int hold);
    I_uart_rdata = b;
    I_uart_rvalid = 1'b1;
    repeat (hold) tick();
    I_uart_rvalid = 1'b0;
    tick();
  endtask
  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
    send(8'h55, $urandom_range(1, 3));
    send(8'hAA, $urandom_range(1, 3));
    send(a, $urandom_range(1, 3));
    send(h, $urandom_range(1, 3));
    send(l, $urandom_range(1, 3));
    send(c, $urandom_range(1, 3));
  endtask
  task automatic ack_pulse();
    bus.reg_ack = 1'b1;
    tick();
    bus.reg_ack = 1'b0;
  endtask
  task automatic clr_pulse();
    I_err_clr = 1'b1;
    tick();
    I_err_clr = 1'b0;
  endtask
  initial begin
    bus.reg_ack = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(bus.reg_req), 0);
    check("rst_addr", 32'(bus.reg_addr), 0);
    check("rst_wdata", 32'(bus.reg_wdata), 0);
    check("rst_err", 32'(O_err_cnt), 0);
    check("rst_busy", 32'(O_busy), 0);
    I_rstn = 1'b1;
    tick();
    send_frame(8'h03, 8'h12, 8'h34, 8'h25);
    check("good_req", 32'(bus.reg_req), 1);
    check("good_addr", 32'(bus.reg_addr), 32'h03);
    check("good_wdata", 32'(bus.reg_wdata), 32'h1234);
    check("good_err", 32'(O_err_cnt), 0);
    repeat (5) tick();
    check("good_hold", 32'(bus.reg_req), 1);
    ack_pulse();
    check("good_ack_req", 32'(bus.reg_req), 0);
    check("good_ack_busy", 32'(O_busy), 0);
    send_frame(8'h03, 8'h12, 8'h34, 8'h00);
    check("bad_req", 32'(bus.reg_req), 0);
    check("bad_err", 32'(O_err_cnt), 1);
    check("bad_busy", 32'(O_busy), 0);
    clr_pulse();
    check("clr_err", 32'(O_err_cnt), 0);
    send(8'h55, 1);
    send(8'h55, 2);
    send(8'hAA, 1);
    send(8'h01, 1);
    send(8'h00, 1);
    send(8'h02, 3);
    send(8'h03, 1);
    check("resync_req", 32'(bus.reg_req), 1);
    check("resync_addr", 32'(bus.reg_addr), 32'h01);
    check("resync_wdata", 32'(bus.reg_wdata), 32'h0002);
    ack_pulse();
    send_frame(8'hC3, 8'hBE, 8'hEF, 8'hC3 ^ 8'hBE ^ 8'hEF);
    repeat (20) tick();
    send(8'h7E, 1);
    repeat (28) tick();
    check("wait_req", 32'(bus.reg_req), 1);
    check("wait_addr", 32'(bus.reg_addr), 32'hC3);
    check("wait_wdata", 32'(bus.reg_wdata), 32'hBEEF);
    check("wait_err", 32'(O_err_cnt), 1);
    I_uart_rdata = 8'h7E;
    I_uart_rvalid = 1'b1;
    bus.reg_ack = 1'b1;
    tick();
    bus.reg_ack = 1'b0;
    I_uart_rvalid = 1'b0;
    check("ackbyte_req", 32'(bus.reg_req), 0);
    check("ackbyte_err", 32'(O_err_cnt), 2);
    tick();
    ack_pulse();
    check("stray_ack_busy", 32'(O_busy), 0);
    clr_pulse();
    for (int i = 0; i < 260; i++) send_frame(8'h03, 8'h12, 8'h34, 8'h00);
    check("sat_err", 32'(O_err_cnt), 32'hFF);
    send(8'h55, 1);
    send(8'hAA, 1);
    send(8'h03, 1);
    send(8'h12, 1);
    send(8'h34, 1);
    I_uart_rdata = 8'h00;
    I_uart_rvalid = 1'b1;
    I_err_clr = 1'b1;
    tick();
    I_err_clr = 1'b0;
    I_uart_rvalid = 1'b0;
    check("clr_prio_err", 32'(O_err_cnt), 0);
    tick();
    send(8'h55, 1);
    send(8'hAA, 1);
    send(8'h03, 1);
    repeat (TO + 10) tick();
`ifdef UART_CMD_TIMEOUT_EN
    check("tmo_busy", 32'(O_busy), 0);
    check("tmo_err", 32'(O_err_cnt), 1);
`else
    check("notmo_busy", 32'(O_busy), 1);
    send(8'h12, 1);
    send(8'h34, 1);
    send(8'h25, 1);
    check("notmo_req", 32'(bus.reg_req), 1);
    check("notmo_addr", 32'(bus.reg_addr), 32'h03);
    check("notmo_wdata", 32'(bus.reg_wdata), 32'h1234);
    ack_pulse();
`endif
    send(8'h55, 1);
    send(8'hAA, 1);
    send(8'h09, 1);
    I_rstn = 1'b0;
    tick();
    I_rstn = 1'b1;
    check("midrst_busy", 32'(O_busy), 0);
    check("midrst_req", 32'(bus.reg_req), 0);
    check("midrst_addr", 32'(bus.reg_addr), 0);
    check("midrst_err", 32'(O_err_cnt), 0);
    send_frame(8'h44, 8'h55, 8'h66, 8'h44 ^ 8'h55 ^ 8'h66);
    I_rstn = 1'b0;
    tick();
    I_rstn = 1'b1;
    check("reqrst_req", 32'(bus.reg_req), 0);
    check("reqrst_wdata", 32'(bus.reg_wdata), 0);
    for (int n = 0; n < 300; n++) begin
      logic [7:0] a, h, l;
      a = 8'($urandom);
      h = 8'($urandom);
      l = 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          if ($urandom_range(0, 3) == 0) send(8'h55, 1);
          send_frame(a, h, l, a ^ h ^ l);
        end
        3: send_frame(a, h, l, a ^ h ^ l ^ 8'($urandom_range(1, 255)));
        4: repeat ($urandom_range(1, 3)) send(8'($urandom), $urandom_range(1, 2));
        default: begin
          send(8'h55, 1);
          send($urandom_range(0, 1) ? 8'hAA : 8'($urandom), 1);
        end
      endcase
      if (m_pend) begin
        repeat ($urandom_range(0, 5)) tick();
        if ($urandom_range(0, 3) == 0) send(8'($urandom), 1);
        if ($urandom_range(0, 3) == 0) begin
          I_uart_rdata = 8'($urandom);
          I_uart_rvalid = 1'b1;
          ack_pulse();
          I_uart_rvalid = 1'b0;
          tick();
        end else ack_pulse();
      end else if ($urandom_range(0, 9) == 0) ack_pulse();
      if ($urandom_range(0, 9) == 0) clr_pulse();
      repeat ($urandom_range(0, 3)) tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
